// File: rtl/cic_int_gain_norm.sv
// CIC interpolator width adaptation: sign-extends input samples to the
// integrator width and removes the rate-dependent bit gain on the way out.
module cic_int_gain_norm #(
  parameter int bw = 16,
  parameter int N = 4,
  parameter int log2_of_max_rate = 7,
  parameter int maxbitgain = (N - 1) * log2_of_max_rate
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               rate,
  input  logic [bw-1:0]            signal_in,
  output logic [bw+maxbitgain-1:0] signal_in_ext,
  input  logic [bw+maxbitgain-1:0] signal_unnorm,
  output logic [bw-1:0]            signal_out
);

  localparam int W = bw + maxbitgain;
  localparam int PW = 8 * (N - 1);
  localparam int SW = $clog2(maxbitgain + 1);
  localparam logic [8:0] MAXR = 9'(1 << log2_of_max_rate);

  logic [PW-1:0] gain;
  logic [SW-1:0] shift;
  logic          rate_ok;

  assign rate_ok = (rate != 8'd0) && ({1'b0, rate} <= MAXR);

  // gain = rate^(N-1); the shift is the smallest power of two covering it
  always_comb begin
    gain = PW'(1);
    for (int i = 0; i < N - 1; i++) begin
      gain = PW'(gain * PW'(rate));
    end
  end

  always_comb begin
    shift = SW'(maxbitgain);
    for (int k = maxbitgain; k >= 0; k--) begin
      if (gain <= (PW'(1) << k)) begin
        shift = SW'(k);
      end
    end
    if (!rate_ok) begin
      shift = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      signal_in_ext <= '0;
      signal_out    <= '0;
    end else if (enable) begin
      signal_in_ext <= {{maxbitgain{signal_in[bw-1]}}, signal_in};
      signal_out    <= bw'(signal_unnorm >> shift);
    end
  end

endmodule

// File: tb/tb_cic_int_gain_norm.sv
// Self-checking bench for cic_int_gain_norm: directed cases plus
// randomized traffic against a table-driven reference model.
module tb_cic_int_gain_norm;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  rate;
  logic [15:0] signal_in;
  logic [36:0] signal_in_ext;
  logic [36:0] signal_unnorm;
  logic [15:0] signal_out;

  int tests;
  int fails;

  localparam int HI [19] = '{1, 2, 3, 4, 5, 6, 8, 10, 12, 16, 20,
                             25, 32, 40, 50, 64, 80, 101, 128};
  localparam int SH [19] = '{0, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13,
                             14, 15, 16, 17, 18, 19, 20, 21};

  cic_int_gain_norm dut (
    .clock(clk),
    .reset(reset),
    .enable(enable),
    .rate(rate),
    .signal_in(signal_in),
    .signal_in_ext(signal_in_ext),
    .signal_unnorm(signal_unnorm),
    .signal_out(signal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_shift(int r);
    if (r < 1) return 0;
    for (int i = 0; i < 19; i++) begin
      if (r <= HI[i]) return SH[i];
    end
    return 0;
  endfunction

  function automatic logic [15:0] ref_out(int r, logic [36:0] u);
    logic [36:0] t;
    t = u >> ref_shift(r);
    return t[15:0];
  endfunction

  function automatic logic [36:0] ref_ext(logic [15:0] s);
    longint v;
    v = longint'($signed(s));
    return v[36:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    rate = 8'd8;
    signal_in = 16'h1234;
    signal_unnorm = 37'h1F_FFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      step();
      tests++;
      if (signal_in_ext !== 37'd0 || signal_out !== 16'd0) begin
        fails++;
        $display("FAIL reset cyc%0d: ext=%h out=%h want 0 0",
                 c, signal_in_ext, signal_out);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_sign_ext();
    logic [15:0] v [2];
    v[0] = 16'h8001;
    v[1] = 16'h7FFF;
    for (int i = 0; i < 2; i++) begin
      signal_in = v[i];
      step();
      tests++;
      if (signal_in_ext !== ref_ext(v[i])) begin
        fails++;
        $display("FAIL sign_ext %h: got %h want %h",
                 v[i], signal_in_ext, ref_ext(v[i]));
      end
    end
    tests++;
    if (signal_in_ext[36:16] !== 21'd0) begin
      fails++;
      $display("FAIL sign_ext_upper: got %h want 0",
               signal_in_ext[36:16]);
    end
  endtask

  task automatic test_norm_fixed();
    rate = 8'd128;
    signal_unnorm = 37'h10_0000_0000;
    step();
    tests++;
    if (signal_out !== 16'h8000) begin
      fails++;
      $display("FAIL norm_r128: got %h want 8000", signal_out);
    end
    rate = 8'd4;
    signal_unnorm = 37'h1234 << 6;
    step();
    tests++;
    if (signal_out !== 16'h1234) begin
      fails++;
      $display("FAIL norm_r4: got %h want 1234", signal_out);
    end
  endtask

  task automatic test_rate_sweep();
    for (int r = 0; r < 256; r++) begin
      rate = 8'(r);
      signal_unnorm = 37'd1 << ref_shift(r);
      step();
      tests++;
      if (signal_out !== 16'h0001) begin
        fails++;
        $display("FAIL sweep rate=%0d: got %h want 0001",
                 r, signal_out);
      end
    end
  endtask

  task automatic test_truncation();
    rate = 8'd5;
    signal_unnorm = 37'h7F;
    step();
    tests++;
    if (signal_out !== 16'h0000) begin
      fails++;
      $display("FAIL trunc_7f: got %h want 0000", signal_out);
    end
    signal_unnorm = '1;
    step();
    tests++;
    if (signal_out !== 16'hFFFF) begin
      fails++;
      $display("FAIL trunc_ones: got %h want ffff", signal_out);
    end
  endtask

  task automatic test_enable_hold();
    logic [36:0] he;
    logic [15:0] ho;
    enable = 1'b1;
    rate = 8'd16;
    signal_in = 16'hA5A5;
    signal_unnorm = 37'h0A_BCD0_0000;
    step();
    he = ref_ext(16'hA5A5);
    ho = ref_out(16, 37'h0A_BCD0_0000);
    enable = 1'b0;
    signal_in = 16'h1357;
    rate = 8'd2;
    signal_unnorm = 37'h0_0000_9998;
    for (int c = 0; c < 2; c++) begin
      step();
      tests++;
      if (signal_in_ext !== he || signal_out !== ho) begin
        fails++;
        $display("FAIL hold cyc%0d: ext=%h out=%h want %h %h",
                 c, signal_in_ext, signal_out, he, ho);
      end
    end
    enable = 1'b1;
    step();
    tests++;
    if (signal_in_ext !== ref_ext(16'h1357) ||
        signal_out !== ref_out(2, 37'h0_0000_9998)) begin
      fails++;
      $display("FAIL resume: ext=%h out=%h want %h %h",
               signal_in_ext, signal_out, ref_ext(16'h1357),
               ref_out(2, 37'h0_0000_9998));
    end
  endtask

  task automatic test_reset_midstream();
    rate = 8'd1;
    signal_in = 16'hFFF0;
    signal_unnorm = 37'h0_0000_4321;
    reset = 1'b1;
    step();
    tests++;
    if (signal_in_ext !== 37'd0 || signal_out !== 16'd0) begin
      fails++;
      $display("FAIL mid_reset: ext=%h out=%h want 0 0",
               signal_in_ext, signal_out);
    end
    reset = 1'b0;
    step();
    tests++;
    if (signal_in_ext !== ref_ext(16'hFFF0) || signal_out !== 16'h4321) begin
      fails++;
      $display("FAIL post_reset: ext=%h out=%h want %h 4321",
               signal_in_ext, signal_out, ref_ext(16'hFFF0));
    end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] s;
    logic [36:0] u;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 255));
      s = 16'($urandom());
      u = 37'({$urandom(), $urandom()});
      rate = 8'(r);
      signal_in = s;
      signal_unnorm = u;
      step();
      tests++;
      if (signal_in_ext !== ref_ext(s) || signal_out !== ref_out(r, u)) begin
        fails++;
        $display("FAIL random r=%0d u=%h: ext=%h out=%h want %h %h",
                 r, u, signal_in_ext, signal_out, ref_ext(s), ref_out(r, u));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    enable = 1'b0;
    rate = 8'd0;
    signal_in = '0;
    signal_unnorm = '0;
    test_reset();
    test_sign_ext();
    test_norm_fixed();
    test_rate_sweep();
    test_truncation();
    test_enable_hold();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
